// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - three-client SDRAM arbiter with read-streak bound and hang watchdog
//
// Purpose:
//   Shares one SDRAM controller between a video reader (highest priority), a terminal
//   writer and a bulk writer. One ram operation is outstanding at a time. Reads may
//   pre-empt writes for at most MAX_READ_STREAK consecutive grants, the two writers are
//   served round-robin, and a watchdog retires any op the ram never completes.
//
// Ports:
//   clk, rst_n                        clock, synchronous active-low reset
//   v_rd_request/_address             video read request (level) and address
//   v_rd_available/_data              1-cycle completion pulse, read data (held)
//   t_wr_request/_address/_data/_mask terminal write request (level) and payload
//   t_wr_done                         1-cycle terminal completion pulse
//   b_wr_*                            bulk writer, same as t_wr_*
//   m_rd_request/_address             read request to ram, held until m_rd_available
//   m_rd_available/_data              ram read completion and data
//   m_wr_request/_address/_data/_mask write request to ram, held until m_wr_done
//   m_wr_done                         ram write completion
//   busy                              high whenever the arbiter is not idle
//   timeout_error                     sticky: some ram op hit the watchdog

module ram_arbiter #(
   parameter int ADDR_WIDTH      = 23,
   parameter int DATA_WIDTH      = 32,
   parameter int MASK_WIDTH      = 4,
   parameter int MAX_READ_STREAK = 8,
   parameter int TIMEOUT_CYCLES  = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  v_rd_request,
   input  logic [ADDR_WIDTH-1:0] v_rd_address,
   output logic                  v_rd_available,
   output logic [DATA_WIDTH-1:0] v_rd_data,
   input  logic                  t_wr_request,
   input  logic [ADDR_WIDTH-1:0] t_wr_address,
   input  logic [DATA_WIDTH-1:0] t_wr_data,
   input  logic [MASK_WIDTH-1:0] t_wr_mask,
   output logic                  t_wr_done,
   input  logic                  b_wr_request,
   input  logic [ADDR_WIDTH-1:0] b_wr_address,
   input  logic [DATA_WIDTH-1:0] b_wr_data,
   input  logic [MASK_WIDTH-1:0] b_wr_mask,
   output logic                  b_wr_done,
   output logic                  m_rd_request,
   output logic [ADDR_WIDTH-1:0] m_rd_address,
   input  logic                  m_rd_available,
   input  logic [DATA_WIDTH-1:0] m_rd_data,
   output logic                  m_wr_request,
   output logic [ADDR_WIDTH-1:0] m_wr_address,
   output logic [DATA_WIDTH-1:0] m_wr_data,
   output logic [MASK_WIDTH-1:0] m_wr_mask,
   input  logic                  m_wr_done,
   output logic                  busy,
   output logic                  timeout_error
);

   localparam int SW = $clog2(MAX_READ_STREAK + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_READ_STREAK);
   localparam logic [TW-1:0] WD_LAST    = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic [SW-1:0]   r_read_streak;
   logic            r_last_bulk;     // writer served most recently (1 = bulk)
   logic            r_served_bulk;   // writer owning the op in flight
   logic [TW-1:0]   r_wd;

   logic            w_write_pend;
   logic            w_streak_full;
   logic            w_grant_read;
   logic            w_grant_bulk;
   logic            w_wd_expired;

   assign w_write_pend  = t_wr_request | b_wr_request;
   assign w_streak_full = (r_read_streak == STREAK_MAX);
   // Video wins unless a write has already watched a full streak of reads go by.
   assign w_grant_read  = v_rd_request & ~(w_write_pend & w_streak_full);
   // Bulk wins when it is alone, or on a tie when the terminal went last.
   assign w_grant_bulk  = b_wr_request & (~t_wr_request | ~r_last_bulk);
   // Counter starts at 0 on grant, so this fires on the TIMEOUT_CYCLES-th waiting cycle.
   assign w_wd_expired  = (r_wd == WD_LAST);

   assign busy = (r_state != S_IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_grant_read) begin
               w_state_next = S_READ;
            end else if (w_write_pend) begin
               w_state_next = S_WRITE;
            end
         end
         S_READ: begin
            if (m_rd_available || w_wd_expired) begin
               w_state_next = S_DONE;
            end
         end
         S_WRITE: begin
            if (m_wr_done || w_wd_expired) begin
               w_state_next = S_DONE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_read_streak  <= '0;
         r_last_bulk    <= 1'b1;
         r_served_bulk  <= 1'b0;
         r_wd           <= '0;
         m_rd_request   <= 1'b0;
         m_rd_address   <= '0;
         m_wr_request   <= 1'b0;
         m_wr_address   <= '0;
         m_wr_data      <= '0;
         m_wr_mask      <= '0;
         v_rd_available <= 1'b0;
         v_rd_data      <= '0;
         t_wr_done      <= 1'b0;
         b_wr_done      <= 1'b0;
         timeout_error  <= 1'b0;
      end else begin
         // Completion pulses are high only for the single DONE cycle.
         v_rd_available <= 1'b0;
         t_wr_done      <= 1'b0;
         b_wr_done      <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_wd <= '0;
               if (w_grant_read) begin
                  m_rd_request <= 1'b1;
                  m_rd_address <= v_rd_address;
                  if (!w_streak_full) begin
                     r_read_streak <= r_read_streak + SW'(1);
                  end
               end else if (w_write_pend) begin
                  m_wr_request  <= 1'b1;
                  m_wr_address  <= w_grant_bulk ? b_wr_address : t_wr_address;
                  m_wr_data     <= w_grant_bulk ? b_wr_data    : t_wr_data;
                  m_wr_mask     <= w_grant_bulk ? b_wr_mask    : t_wr_mask;
                  r_last_bulk   <= w_grant_bulk;
                  r_served_bulk <= w_grant_bulk;
                  r_read_streak <= '0;
               end else begin
                  r_read_streak <= '0;
               end
            end
            S_READ: begin
               if (m_rd_available) begin
                  v_rd_data      <= m_rd_data;
                  m_rd_request   <= 1'b0;
                  v_rd_available <= 1'b1;
               end else if (w_wd_expired) begin
                  // The client is still released, but with zero data.
                  v_rd_data      <= '0;
                  m_rd_request   <= 1'b0;
                  v_rd_available <= 1'b1;
                  timeout_error  <= 1'b1;
               end else begin
                  r_wd <= r_wd + TW'(1);
               end
            end
            S_WRITE: begin
               if (m_wr_done || w_wd_expired) begin
                  m_wr_request <= 1'b0;
                  t_wr_done    <= ~r_served_bulk;
                  b_wr_done    <= r_served_bulk;
                  if (!m_wr_done) begin
                     timeout_error <= 1'b1;
                  end
               end else begin
                  r_wd <= r_wd + TW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - scoreboard bench for ram_arbiter with a rule-level arbitration model
`timescale 1ns/1ps
module tb_ram_arbiter;
   localparam int AW   = 23;
   localparam int DW   = 32;
   localparam int MW   = 4;
   localparam int MAXS = 8;
   localparam int TO   = 1024;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          v_rd_request = 1'b0;
   logic [AW-1:0] v_rd_address = '0;
   logic          v_rd_available;
   logic [DW-1:0] v_rd_data;
   logic          t_wr_request = 1'b0;
   logic [AW-1:0] t_wr_address = '0;
   logic [DW-1:0] t_wr_data = '0;
   logic [MW-1:0] t_wr_mask = '0;
   logic          t_wr_done;
   logic          b_wr_request = 1'b0;
   logic [AW-1:0] b_wr_address = '0;
   logic [DW-1:0] b_wr_data = '0;
   logic [MW-1:0] b_wr_mask = '0;
   logic          b_wr_done;
   logic          m_rd_request;
   logic [AW-1:0] m_rd_address;
   logic          m_rd_available = 1'b0;
   logic [DW-1:0] m_rd_data = '0;
   logic          m_wr_request;
   logic [AW-1:0] m_wr_address;
   logic [DW-1:0] m_wr_data;
   logic [MW-1:0] m_wr_mask;
   logic          m_wr_done = 1'b0;
   logic          busy;
   logic          timeout_error;

   ram_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW),
      .MAX_READ_STREAK(MAXS), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .v_rd_request(v_rd_request), .v_rd_address(v_rd_address),
      .v_rd_available(v_rd_available), .v_rd_data(v_rd_data),
      .t_wr_request(t_wr_request), .t_wr_address(t_wr_address), .t_wr_data(t_wr_data),
      .t_wr_mask(t_wr_mask), .t_wr_done(t_wr_done),
      .b_wr_request(b_wr_request), .b_wr_address(b_wr_address), .b_wr_data(b_wr_data),
      .b_wr_mask(b_wr_mask), .b_wr_done(b_wr_done),
      .m_rd_request(m_rd_request), .m_rd_address(m_rd_address),
      .m_rd_available(m_rd_available), .m_rd_data(m_rd_data),
      .m_wr_request(m_wr_request), .m_wr_address(m_wr_address), .m_wr_data(m_wr_data),
      .m_wr_mask(m_wr_mask), .m_wr_done(m_wr_done),
      .busy(busy), .timeout_error(timeout_error)
   );

   always #5 clk = ~clk;

   // Stimulus controls, written only by the main sequence.
   bit auto_mode = 0, want_v = 0, want_t = 0, want_b = 0, fix_v = 0, fix_t = 0;
   bit ram_hang_rd = 0, ram_rand_lat = 0, stray = 0;
   int ram_lat = 3;

   int n_checks = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
   endtask

   function automatic logic [DW-1:0] rd_hash(input logic [AW-1:0] a);
      return 32'hDEADBEEF ^ {{(DW-AW){1'b0}}, a};
   endfunction

   // Ram model: completes the held request after ram latency cycles.
   int ram_cnt = 0;
   int ram_cur_lat = 1;
   always @(negedge clk) begin
      m_rd_available = 1'b0;
      m_wr_done = 1'b0;
      if (m_rd_request || m_wr_request) begin
         if (ram_cnt == 0) ram_cur_lat = ram_rand_lat ? int'($urandom_range(1, 6)) : ram_lat;
         ram_cnt++;
         if (ram_cnt == ram_cur_lat) begin
            if (m_rd_request) begin
               if (!ram_hang_rd) begin
                  m_rd_available = 1'b1;
                  m_rd_data = rd_hash(m_rd_address);
               end
            end else begin
               m_wr_done = 1'b1;
            end
         end
      end else begin
         ram_cnt = 0;
         if (stray) begin
            m_rd_available = 1'b1;
            m_wr_done = 1'b1;
            m_rd_data = 32'h0BAD_0BAD;
         end
      end
   end

   // Clients: hold request until done, then drop or renew with a fresh payload.
   task automatic new_v();
      v_rd_address = fix_v ? '0 : AW'($urandom);
   endtask
   task automatic new_t();
      t_wr_address = fix_t ? 23'h000123 : {1'b0, 22'($urandom)};
      t_wr_data    = fix_t ? 32'h0041_0700 : $urandom;
      t_wr_mask    = fix_t ? 4'b1111 : MW'($urandom);
   endtask
   task automatic new_b();
      b_wr_address = {1'b1, 22'($urandom)};
      b_wr_data    = $urandom;
      b_wr_mask    = MW'($urandom);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (v_rd_request) begin
            if (v_rd_available) begin
               if (auto_mode ? ($urandom_range(0, 1) == 1) : want_v) new_v();
               else v_rd_request = 1'b0;
            end
         end else if (auto_mode ? ($urandom_range(0, 3) == 0) : want_v) begin
            v_rd_request = 1'b1;
            new_v();
         end
         if (t_wr_request) begin
            if (t_wr_done) begin
               if (auto_mode ? ($urandom_range(0, 1) == 1) : want_t) new_t();
               else t_wr_request = 1'b0;
            end
         end else if (auto_mode ? ($urandom_range(0, 3) == 0) : want_t) begin
            t_wr_request = 1'b1;
            new_t();
         end
         if (b_wr_request) begin
            if (b_wr_done) begin
               if (auto_mode ? ($urandom_range(0, 1) == 1) : want_b) new_b();
               else b_wr_request = 1'b0;
            end
         end else if (auto_mode ? ($urandom_range(0, 3) == 0) : want_b) begin
            b_wr_request = 1'b1;
            new_b();
         end
      end
   end

   // Reference model: on every cycle the arbiter was idle, decide from the rules who
   // must have been granted, check the ram request, and queue the expected completion.
   int m_streak = 0;
   bit m_last_b = 1;
   bit prev_busy = 0;
   bit both_seen = 0;
   bit m_wp, m_gb;
   logic [DW-1:0] exp_v[$];
   int exp_t[$];
   int exp_b[$];
   int grant_log[$];   // 0 = video, 1 = terminal, 2 = bulk

   always begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
         m_streak = 0;
         m_last_b = 1;
         prev_busy = 0;
         exp_v.delete();
         exp_t.delete();
         exp_b.delete();
      end else begin
         if (m_rd_request && m_wr_request) both_seen = 1;
         if (!prev_busy) begin
            m_wp = t_wr_request || b_wr_request;
            if (v_rd_request && !(m_wp && m_streak == MAXS)) begin
               if (m_streak < MAXS) m_streak++;
               check("grant_read", {m_rd_request, m_wr_request, busy}, 3'b101);
               check("grant_rd_address", m_rd_address, v_rd_address);
               exp_v.push_back(ram_hang_rd ? {DW{1'b0}} : rd_hash(v_rd_address));
               grant_log.push_back(0);
            end else if (m_wp) begin
               m_gb = b_wr_request && (!t_wr_request || !m_last_b);
               m_last_b = m_gb;
               m_streak = 0;
               check("grant_write", {m_rd_request, m_wr_request, busy}, 3'b011);
               check("grant_wr_address", m_wr_address, m_gb ? b_wr_address : t_wr_address);
               check("grant_wr_data", m_wr_data, m_gb ? b_wr_data : t_wr_data);
               check("grant_wr_mask", m_wr_mask, m_gb ? b_wr_mask : t_wr_mask);
               if (m_gb) exp_b.push_back(1);
               else exp_t.push_back(1);
               grant_log.push_back(m_gb ? 2 : 1);
            end else begin
               m_streak = 0;
               check("idle_no_grant", {m_rd_request, m_wr_request, busy}, 3'b000);
            end
         end
         prev_busy = busy;
      end
   end

   // Completion monitor: pops the scoreboard whenever the DUT pulses a done/available.
   always begin
      @(posedge clk);
      #1;
      if (rst_n) begin
         if (v_rd_available) begin
            if (exp_v.size() == 0) check("v_spurious_available", v_rd_available, 1'b0);
            else check("v_rd_data", v_rd_data, exp_v.pop_front());
         end
         if (t_wr_done) begin
            if (exp_t.size() == 0) check("t_spurious_done", t_wr_done, 1'b0);
            else begin
               void'(exp_t.pop_front());
               check("t_done_exclusive", {v_rd_available, t_wr_done, b_wr_done}, 3'b010);
            end
         end
         if (b_wr_done) begin
            if (exp_b.size() == 0) check("b_spurious_done", b_wr_done, 1'b0);
            else begin
               void'(exp_b.pop_front());
               check("b_done_exclusive", {v_rd_available, t_wr_done, b_wr_done}, 3'b001);
            end
         end
      end
   end

   task automatic drain();
      int k;
      want_v = 0;
      want_t = 0;
      want_b = 0;
      k = 0;
      do begin
         @(posedge clk);
         #1;
         k++;
      end while ((busy || v_rd_request || t_wr_request || b_wr_request) && k < 3000);
      check("drain_idle", {busy, v_rd_request, t_wr_request, b_wr_request}, 4'b0000);
   endtask

   initial begin
      #2ms;
      $display("FAIL global_timeout: simulation did not finish, required finish before 2ms");
      $fatal(1, "global timeout");
   end

   initial begin
      int k, cnt, base, expg, done_cnt;
      logic [9:0] rd_bits, av_bits;
      logic [DW-1:0] d5;
      logic [AW-1:0] cap_a;
      logic [DW-1:0] cap_d;
      logic [MW-1:0] cap_m;
      bit got, rd_ever;

      repeat (3) @(negedge clk);
      check("reset_outputs", {v_rd_available, t_wr_done, b_wr_done, m_rd_request,
                              m_wr_request, busy, timeout_error}, 7'b0);
      check("reset_data", {v_rd_data, m_wr_data}, 64'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single video read, ram latency 5.
      ram_lat = 5;
      fix_v = 1;
      want_v = 1;
      k = 0;
      do begin @(posedge clk); #1; k++; end while (!v_rd_request && k < 20);
      want_v = 0;
      d5 = '0;
      for (int i = 0; i < 10; i++) begin
         rd_bits[i] = m_rd_request;
         av_bits[i] = v_rd_available;
         if (i == 5) d5 = v_rd_data;
         @(posedge clk);
         #1;
      end
      check("t1_rd_request_window", rd_bits, 10'b0000011111);
      check("t1_available_pulse", av_bits, 10'b0000100000);
      check("t1_data", d5, 32'hDEADBEEF);
      fix_v = 0;

      // Completion strobes while idle must be ignored.
      repeat (3) @(negedge clk);
      stray = 1;
      @(negedge clk);
      @(posedge clk);
      #1;
      check("stray_busy", busy, 1'b0);
      @(negedge clk);
      stray = 0;
      repeat (3) @(negedge clk);
      check("stray_v_rd_data", v_rd_data, 32'hDEADBEEF);

      // Single terminal write.
      ram_lat = 4;
      fix_t = 1;
      want_t = 1;
      k = 0;
      do begin @(posedge clk); #1; k++; end while (!t_wr_request && k < 20);
      want_t = 0;
      got = 0;
      rd_ever = 0;
      done_cnt = 0;
      cap_a = '0;
      cap_d = '0;
      cap_m = '0;
      for (int i = 0; i < 20; i++) begin
         if (m_wr_request && !got) begin
            got = 1;
            cap_a = m_wr_address;
            cap_d = m_wr_data;
            cap_m = m_wr_mask;
         end
         if (m_rd_request) rd_ever = 1;
         if (t_wr_done) done_cnt++;
         @(posedge clk);
         #1;
      end
      check("t2_wr_address", cap_a, 23'h000123);
      check("t2_wr_data", cap_d, 32'h0041_0700);
      check("t2_wr_mask", cap_m, 4'b1111);
      check("t2_done_pulses", done_cnt, 1);
      check("t2_no_read", rd_ever, 1'b0);
      fix_t = 0;
      drain();

      // All three held: V x8 then a writer, writers alternating (terminal went last).
      ram_lat = 1;
      base = grant_log.size();
      want_v = 1;
      want_t = 1;
      want_b = 1;
      k = 0;
      do begin @(posedge clk); #1; k++; end while (grant_log.size() < base + 27 && k < 3000);
      drain();
      check("t3_grant_count", grant_log.size() >= base + 27, 1'b1);
      for (int g = 0; g < 27; g++) begin
         expg = (g % 9 != 8) ? 0 : (((g / 9) % 2 == 0) ? 2 : 1);
         if (grant_log.size() > base + g) check("t3_grant_order", grant_log[base + g], expg);
      end

      // Writers only: strict alternation starting with the writer that did not go last.
      base = grant_log.size();
      expg = m_last_b ? 1 : 2;
      want_t = 1;
      want_b = 1;
      k = 0;
      do begin @(posedge clk); #1; k++; end while (grant_log.size() < base + 6 && k < 3000);
      drain();
      check("t4_grant_count", grant_log.size() >= base + 6, 1'b1);
      for (int g = 0; g < 6; g++) begin
         if (grant_log.size() > base + g) check("t4_alternation", grant_log[base + g], expg);
         expg = 3 - expg;
      end

      // Ram never completes a read: watchdog.
      ram_lat = 2;
      check("t5_timeout_initially_clear", timeout_error, 1'b0);
      ram_hang_rd = 1;
      want_v = 1;
      k = 0;
      do begin @(posedge clk); #1; k++; end while (!v_rd_request && k < 20);
      want_v = 0;
      cnt = 0;
      k = 0;
      while (k < 1100) begin
         if (m_rd_request) cnt++;
         else if (cnt > 0) break;
         @(posedge clk);
         #1;
         k++;
      end
      check("t5_rd_request_cycles", cnt, TO);
      check("t5_timeout_error", timeout_error, 1'b1);
      check("t5_available_on_timeout", v_rd_available, 1'b1);
      ram_hang_rd = 0;
      repeat (3) @(negedge clk);
      want_v = 1;
      k = 0;
      do begin @(posedge clk); #1; k++; end while (!v_rd_request && k < 20);
      want_v = 0;
      k = 0;
      do begin @(posedge clk); #1; k++; end while (!v_rd_available && k < 40);
      check("t5_next_read_served", v_rd_available, 1'b1);
      check("t5_timeout_sticky", timeout_error, 1'b1);
      drain();

      // Reset in the middle of a write.
      ram_lat = 8;
      want_t = 1;
      want_b = 1;
      k = 0;
      do begin @(posedge clk); #1; k++; end while (!m_wr_request && k < 40);
      check("t6_write_started", m_wr_request, 1'b1);
      repeat (2) begin @(posedge clk); #1; end
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("t6_reset_drops_request", {m_wr_request, busy}, 2'b00);
      check("t6_no_done", {t_wr_done, b_wr_done}, 2'b00);
      check("t6_timeout_cleared", timeout_error, 1'b0);
      repeat (2) @(negedge clk);
      base = grant_log.size();
      rst_n = 1'b1;
      k = 0;
      do begin @(posedge clk); #1; k++; end while (grant_log.size() < base + 1 && k < 40);
      if (grant_log.size() > base) check("t6_first_grant_terminal", grant_log[base], 1);
      else check("t6_first_grant_seen", busy, 1'b1);
      drain();

      // Randomized traffic against the reference model.
      ram_rand_lat = 1;
      auto_mode = 1;
      repeat (4000) @(negedge clk);
      auto_mode = 0;
      drain();
      ram_rand_lat = 0;

      repeat (5) @(negedge clk);
      check("final_v_queue_empty", exp_v.size(), 0);
      check("final_t_queue_empty", exp_t.size(), 0);
      check("final_b_queue_empty", exp_b.size(), 0);
      check("never_rd_and_wr_together", both_seen, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
